// File: rtl/tetrimino_locker.sv
// Lock stage of the drop path: merges a landed piece into the settled board,
// then scans bottom-up and collapses every full row before reporting back.
module tetrimino_locker #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int TOT_W = 8,
    localparam int YW   = $clog2(ROWS),
    localparam int XW   = $clog2(COLS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_board,
    input  logic                           lock_req,
    input  logic [XW-1:0]                  inX3,
    input  logic [XW-1:0]                  inX2,
    input  logic [XW-1:0]                  inX1,
    input  logic [XW-1:0]                  inX0,
    input  logic [YW-1:0]                  inY3,
    input  logic [YW-1:0]                  inY2,
    input  logic [YW-1:0]                  inY1,
    input  logic [YW-1:0]                  inY0,
    output logic [ROWS-1:0][COLS-1:0]      matrixOut,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     lines_cleared,
    output logic [TOT_W-1:0]               total_lines,
    output logic                           top_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [YW-1:0] ROW_LAST = YW'(ROWS - 1);

    state_t                   state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] board_q, board_d;
    logic [YW-1:0]            row_q, row_d;
    logic [3:0]               lines_q, lines_d;
    logic [TOT_W-1:0]         total_q, total_d;
    logic                     top_q, top_d;

    logic [XW-1:0]            cell_x [4];
    logic [YW-1:0]            cell_y [4];
    logic [ROWS-1:0][COLS-1:0] piece_mask;

    assign cell_x[0] = inX0;
    assign cell_x[1] = inX1;
    assign cell_x[2] = inX2;
    assign cell_x[3] = inX3;
    assign cell_y[0] = inY0;
    assign cell_y[1] = inY1;
    assign cell_y[2] = inY2;
    assign cell_y[3] = inY3;

    // Duplicate or already-occupied cells simply OR in; no error path exists.
    always_comb begin
        piece_mask = '0;
        for (int i = 0; i < 4; i++) begin
            piece_mask[cell_y[i]][cell_x[i]] = 1'b1;
        end
    end

    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        row_d   = row_q;
        lines_d = lines_q;
        total_d = total_q;
        top_d   = top_q;

        if (clear_board) begin
            state_d = IDLE;
            board_d = '0;
            row_d   = ROW_LAST;
            lines_d = '0;
            total_d = '0;
            top_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lock_req) begin
                        board_d = board_q | piece_mask;
                        lines_d = '0;
                        row_d   = ROW_LAST;
                        state_d = SCAN;
                    end
                end

                SCAN: begin
                    if (&board_q[row_q]) begin
                        // Shift everything above the full row down by one; r stays put so
                        // the row that dropped into place is examined on the next edge.
                        for (int y = 1; y < ROWS; y++) begin
                            if (YW'(y) <= row_q) begin
                                board_d[y] = board_q[y-1];
                            end
                        end
                        board_d[0] = '0;
                        lines_d    = lines_q + 4'd1;
                        total_d    = (total_q == '1) ? total_q : total_q + 1'b1;
                    end else if (row_q != '0) begin
                        row_d = row_q - 1'b1;
                    end else begin
                        state_d = DONE;
                        top_d   = top_q | (|board_q[0]);
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: the board is a plain flop array, not a RAM, so it can and must be reset with the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            board_q <= '0;
            row_q   <= ROW_LAST;
            lines_q <= '0;
            total_q <= '0;
            top_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            total_q <= total_d;
            top_q   <= top_d;
        end
    end

    assign matrixOut     = board_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;
    assign top_out       = top_q;

endmodule
